// File: rtl/ntps_reset_sequencer_if.sv
// ----------------------------------------------------------------------------
// ntps_reset_sequencer_if
//
// Purpose : bundles the control/status signals of the NTP datapath reset
//           sequencer so the sequencer and its environment share one typed
//           connection.
//
// Signals :
//   pll_locked     PLL lock indication, asynchronous to the sequencer clock
//   soft_rst_req   single-cycle soft-reset strobe from a host register
//   stage_rst_n    active-low per-subsystem resets, thermometer coded
//   seq_done       high while every stage is released
//   lock_lost_cnt  saturating count of PLL lock-loss events
//
// Modports:
//   master  environment side: drives pll_locked / soft_rst_req
//   slave   sequencer side : drives the reset and status outputs
//
// Handshake: there is no valid/ready pair on this bundle. soft_rst_req is a
// one-cycle strobe that the sequencer samples on every clock edge and either
// acts on (RELEASE/RUN/SOFT) or drops (HOLD); it is never back-pressured.
// ----------------------------------------------------------------------------
interface ntps_reset_sequencer_if #(
    parameter int NUM_STAGES = 4
);
    logic                  pll_locked;
    logic                  soft_rst_req;
    logic [NUM_STAGES-1:0] stage_rst_n;
    logic                  seq_done;
    logic [7:0]            lock_lost_cnt;

    modport master (
        output pll_locked,
        output soft_rst_req,
        input  stage_rst_n,
        input  seq_done,
        input  lock_lost_cnt
    );

    modport slave (
        input  pll_locked,
        input  soft_rst_req,
        output stage_rst_n,
        output seq_done,
        output lock_lost_cnt
    );
endinterface

// File: rtl/ntps_reset_sequencer.sv
// ----------------------------------------------------------------------------
// ntps_reset_sequencer
//
// Purpose : staged reset sequencer for the NTP datapath. Holds every
//           subsystem in reset until the clocking PLL has been stably locked,
//           then releases the subsystem resets one by one (stage 0 first)
//           with a fixed spacing. Offers a host-triggered soft reset with a
//           guaranteed minimum width and counts PLL lock-loss events.
//
// Ports   :
//   i_clk       250 MHz clock, all logic is on this clock
//   i_areset_n  asynchronous active-low reset (peripheral_aresetn)
//   io_seq      slave side of ntps_reset_sequencer_if
//                 in : pll_locked, soft_rst_req
//                 out: stage_rst_n, seq_done, lock_lost_cnt (all registered)
//   o_state     current FSM state (debug visibility)
//                 0 = HOLD, 1 = RELEASE, 2 = RUN, 3 = SOFT
// ----------------------------------------------------------------------------
module ntps_reset_sequencer #(
    parameter int NUM_STAGES  = 4,
    parameter int STAGE_DELAY = 16,
    parameter int LOCK_FILTER = 8,
    parameter int SOFT_PULSE  = 64
) (
    input  logic                          i_clk,
    input  logic                          i_areset_n,
    ntps_reset_sequencer_if.slave         io_seq,
    output logic [1:0]                    o_state
);

    localparam int CNT_MAX = (STAGE_DELAY > SOFT_PULSE) ? STAGE_DELAY : SOFT_PULSE;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam int SW      = $clog2(NUM_STAGES + 1);
    localparam int LW      = $clog2(LOCK_FILTER + 1);

    typedef enum logic [1:0] {
        ST_HOLD    = 2'd0,
        ST_RELEASE = 2'd1,
        ST_RUN     = 2'd2,
        ST_SOFT    = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;

    logic                  r_sync1;
    logic                  r_sync2;
    logic                  w_lock_s;

    logic [LW-1:0]         r_lock_cnt;
    logic                  r_lock_ok;
    logic                  w_lock_ok_nxt;

    logic [CW-1:0]         r_cyc;
    logic [SW-1:0]         r_stage_cnt;
    logic [SW-1:0]         w_rel_cnt_nxt;

    logic                  w_soft_req;
    logic                  w_lock_lost;
    logic                  w_stage_tick;
    logic                  w_last_stage;
    logic                  w_pulse_done;

    logic [NUM_STAGES-1:0] r_stage_rst_n;
    logic [NUM_STAGES-1:0] w_stage_rst_n_nxt;
    logic                  r_seq_done;
    logic                  w_seq_done_nxt;
    logic [7:0]            r_lost_cnt;

    // ------------------------------------------------------------------------
    // PLL lock synchronizer (two flops, cleared by reset)
    // ------------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_areset_n) begin
        if (!i_areset_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= io_seq.pll_locked;
            r_sync2 <= r_sync1;
        end
    end

    assign w_lock_s   = r_sync2;
    assign w_soft_req = io_seq.soft_rst_req;

    // ------------------------------------------------------------------------
    // Lock filter. It only runs in HOLD, so every return to HOLD (soft reset
    // or lock loss) re-qualifies the lock from scratch. The HOLD exit is
    // taken on the same edge that sets lock_ok, so RELEASE begins exactly
    // LOCK_FILTER sampled-high cycles after the synchronized lock rises.
    // ------------------------------------------------------------------------
    assign w_lock_ok_nxt = w_lock_s && (r_state == ST_HOLD) &&
                           (r_lock_ok || (r_lock_cnt == LW'(LOCK_FILTER - 1)));

    always_ff @(posedge i_clk or negedge i_areset_n) begin
        if (!i_areset_n) begin
            r_lock_cnt <= '0;
            r_lock_ok  <= 1'b0;
        end else if (!w_lock_s || (r_state != ST_HOLD)) begin
            r_lock_cnt <= '0;
            r_lock_ok  <= 1'b0;
        end else begin
            r_lock_ok <= w_lock_ok_nxt;
            if (!w_lock_ok_nxt) begin
                r_lock_cnt <= r_lock_cnt + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Event decodes
    // ------------------------------------------------------------------------
    // Lock loss only counts once sequencing has started; in HOLD it is
    // absorbed by the filter.
    assign w_lock_lost  = !w_lock_s && (r_state != ST_HOLD);
    assign w_stage_tick = (r_state == ST_RELEASE) && (r_cyc == CW'(STAGE_DELAY - 1));
    assign w_last_stage = (r_stage_cnt == SW'(NUM_STAGES - 1));
    assign w_pulse_done = (r_cyc == CW'(SOFT_PULSE - 1));

    // ------------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_areset_n) begin
        if (!i_areset_n) begin
            r_state <= ST_HOLD;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // FSM: next state. Priority is lock loss, then soft request, then
    // normal sequencing.
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_HOLD: begin
                if (w_lock_ok_nxt) begin
                    w_state_nxt = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                if (w_lock_lost) begin
                    w_state_nxt = ST_HOLD;
                end else if (w_soft_req) begin
                    w_state_nxt = ST_SOFT;
                end else if (w_stage_tick && w_last_stage) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (w_lock_lost) begin
                    w_state_nxt = ST_HOLD;
                end else if (w_soft_req) begin
                    w_state_nxt = ST_SOFT;
                end
            end
            ST_SOFT: begin
                if (w_lock_lost) begin
                    w_state_nxt = ST_HOLD;
                end else if (!w_soft_req && w_pulse_done) begin
                    w_state_nxt = ST_HOLD;
                end
            end
            default: w_state_nxt = ST_HOLD;
        endcase
    end

    // ------------------------------------------------------------------------
    // FSM: outputs. Computes the number of released stages after the coming
    // edge; the reset vector is its thermometer decode, so reassertion is
    // always all-at-once and release is always lowest-index first.
    // ------------------------------------------------------------------------
    always_comb begin
        w_rel_cnt_nxt = '0;
        case (w_state_nxt)
            ST_RUN: begin
                w_rel_cnt_nxt = SW'(NUM_STAGES);
            end
            ST_RELEASE: begin
                if (r_state == ST_RELEASE) begin
                    w_rel_cnt_nxt = w_stage_tick ? (r_stage_cnt + 1'b1) : r_stage_cnt;
                end
            end
            default: w_rel_cnt_nxt = '0;
        endcase

        w_seq_done_nxt = (w_state_nxt == ST_RUN);

        w_stage_rst_n_nxt = '0;
        for (int i = 0; i < NUM_STAGES; i++) begin
            w_stage_rst_n_nxt[i] = (SW'(i) < w_rel_cnt_nxt);
        end
    end

    // ------------------------------------------------------------------------
    // Cycle counter: stage spacing in RELEASE, pulse width in SOFT. Cleared
    // on every state change; a repeated soft request restarts the pulse.
    // ------------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_areset_n) begin
        if (!i_areset_n) begin
            r_cyc <= '0;
        end else if (w_state_nxt != r_state) begin
            r_cyc <= '0;
        end else begin
            case (r_state)
                ST_RELEASE: r_cyc <= w_stage_tick ? '0 : (r_cyc + 1'b1);
                ST_SOFT:    r_cyc <= w_soft_req   ? '0 : (r_cyc + 1'b1);
                default:    r_cyc <= '0;
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Registered outputs and lock-loss counter
    // ------------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_areset_n) begin
        if (!i_areset_n) begin
            r_stage_cnt   <= '0;
            r_stage_rst_n <= '0;
            r_seq_done    <= 1'b0;
            r_lost_cnt    <= 8'd0;
        end else begin
            r_stage_cnt   <= w_rel_cnt_nxt;
            r_stage_rst_n <= w_stage_rst_n_nxt;
            r_seq_done    <= w_seq_done_nxt;
            if (w_lock_lost && (r_lost_cnt != 8'hFF)) begin
                r_lost_cnt <= r_lost_cnt + 8'd1;
            end
        end
    end

    assign io_seq.stage_rst_n   = r_stage_rst_n;
    assign io_seq.seq_done      = r_seq_done;
    assign io_seq.lock_lost_cnt = r_lost_cnt;
    assign o_state              = r_state;

endmodule

// File: tb/tb_ntps_reset_sequencer.sv
// ----------------------------------------------------------------------------
// tb_ntps_reset_sequencer
//
// Stimulus tasks drive pll_locked / soft_rst_req at falling edges and push
// the outputs the design must show after specific rising edges into exp_q.
// A monitor at every falling edge pops entries whose edge has been reached
// and compares {stage_rst_n, seq_done, lock_lost_cnt}.
// ----------------------------------------------------------------------------
module tb_ntps_reset_sequencer;

    localparam int NS = 4;
    localparam int SD = 16;
    localparam int LF = 8;
    localparam int SP = 64;
    localparam int OW = NS + 1 + 8;
    localparam int EW = 32 + OW;

    // ---------------- clock / reset ----------------
    logic       clk      = 1'b0;
    logic       areset_n = 1'b1;
    logic [1:0] dbg_state;
    int         cyc      = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ntps_reset_sequencer_if #(.NUM_STAGES(NS)) seq_if ();

    ntps_reset_sequencer #(
        .NUM_STAGES  (NS),
        .STAGE_DELAY (SD),
        .LOCK_FILTER (LF),
        .SOFT_PULSE  (SP)
    ) dut (
        .i_clk      (clk),
        .i_areset_n (areset_n),
        .io_seq     (seq_if),
        .o_state    (dbg_state)
    );

    // ---------------- scoreboard ----------------
    logic [EW-1:0] exp_q[$];
    int            n_cmp = 0;
    int            n_err = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [NS-1:0] therm(input int n);
        logic [NS-1:0] t;
        t = '0;
        for (int i = 0; i < NS; i++) begin
            if (i < n) t[i] = 1'b1;
        end
        return t;
    endfunction

    function automatic logic [OW-1:0] dut_outs();
        return {seq_if.stage_rst_n, seq_if.seq_done, seq_if.lock_lost_cnt};
    endfunction

    task automatic push_exp(input int t, input logic [NS-1:0] st, input logic dn, input logic [7:0] cnt);
        exp_q.push_back({32'(t), st, dn, cnt});
    endtask

    // e = edge at which the synchronized lock is high and the filter may start
    // counting from HOLD; RELEASE is entered LF edges later.
    task automatic expect_sequence(input int e, input int nrel, input logic [7:0] cnt);
        int rel;
        int t;
        rel = e + LF;
        push_exp(rel - 1, '0, 1'b0, cnt);
        for (int k = 0; k < nrel; k++) begin
            t = rel + (k + 1) * SD;
            push_exp(t - 1, therm(k), 1'b0, cnt);
            push_exp(t, therm(k + 1), (k == NS - 1), cnt);
        end
        if (nrel == NS) begin
            push_exp(rel + NS * SD + 5, therm(NS), 1'b1, cnt);
        end
    endtask

    always @(negedge clk) begin
        logic [EW-1:0] e;
        if (exp_q.size() > 0) begin
            e = exp_q[0];
            if (int'(e[EW-1:OW]) <= cyc) begin
                void'(exp_q.pop_front());
                check_val($sformatf("out@%0d", int'(e[EW-1:OW])), 32'(dut_outs()), 32'(e[OW-1:0]));
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic wait_until(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while (exp_q.size() > 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check_val("drain", exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic pulse_soft();
        seq_if.soft_rst_req = 1'b1;
        @(negedge clk);
        seq_if.soft_rst_req = 1'b0;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int         c;
        int         s;
        int         rel;
        logic [7:0] exp_cnt;

        seq_if.pll_locked   = 1'b0;
        seq_if.soft_rst_req = 1'b0;
        #1 areset_n = 1'b0;
        repeat (3) @(negedge clk);
        check_val("reset_outs", 32'(dut_outs()), 32'(0));
        areset_n = 1'b1;
        @(negedge clk);

        // 1: power-up sequence with a steady lock
        c = cyc;
        seq_if.pll_locked = 1'b1;
        expect_sequence(c + 2, NS, 8'd0);
        drain(200);

        // 3: lock loss in RUN
        c = cyc;
        seq_if.pll_locked = 1'b0;
        push_exp(c + 2, therm(NS), 1'b1, 8'd0);
        push_exp(c + 3, '0, 1'b0, 8'd1);
        drain(20);

        // soft request in HOLD is ignored (would otherwise bump the counter)
        pulse_soft();
        repeat (3) @(negedge clk);

        // 2: relock with a one-cycle glitch after 5 high cycles
        c = cyc;
        seq_if.pll_locked = 1'b1;
        wait_until(c + 5);
        seq_if.pll_locked = 1'b0;
        @(negedge clk);
        seq_if.pll_locked = 1'b1;
        expect_sequence(c + 8, NS, 8'd1);
        drain(300);

        // 4a: soft reset in RUN, single request
        c = cyc;
        pulse_soft();
        s = c + 1;
        push_exp(s, '0, 1'b0, 8'd1);
        expect_sequence(s + SP, NS, 8'd1);
        drain(300);

        // 4b: soft reset extended by a second request at cycle 30 of SOFT
        c = cyc;
        pulse_soft();
        s = c + 1;
        push_exp(s, '0, 1'b0, 8'd1);
        wait_until(s + 29);
        pulse_soft();
        expect_sequence(s + 30 + SP, NS, 8'd1);
        drain(300);

        // 5: lock loss and soft request on the same edge during RELEASE
        c = cyc;
        pulse_soft();
        s = c + 1;
        push_exp(s, '0, 1'b0, 8'd1);
        expect_sequence(s + SP, 2, 8'd1);
        wait_until(s + SP + LF + 2 * SD + 6);
        c = cyc;
        push_exp(c + 2, therm(2), 1'b0, 8'd1);
        push_exp(c + 3, '0, 1'b0, 8'd2);
        seq_if.pll_locked = 1'b0;
        wait_until(c + 2);
        pulse_soft();
        seq_if.pll_locked = 1'b1;
        expect_sequence(c + 5, NS, 8'd2);
        drain(300);

        // 6a: 260 lock-loss events, counter saturates
        exp_cnt = 8'd2;
        rel = 0;
        for (int i = 0; i < 260; i++) begin
            c = cyc;
            seq_if.pll_locked = 1'b0;
            exp_cnt = (exp_cnt == 8'hFF) ? 8'hFF : exp_cnt + 8'd1;
            push_exp(c + 3, '0, 1'b0, exp_cnt);
            wait_until(c + 4);
            seq_if.pll_locked = 1'b1;
            rel = c + 6 + LF;
            wait_until(c + 16);
        end
        push_exp(rel + SD - 1, '0, 1'b0, 8'hFF);
        push_exp(rel + SD, therm(1), 1'b0, 8'hFF);
        wait_until(rel + SD + 3);
        drain(10);

        // 6b: asynchronous reset mid-RELEASE clears outputs without an edge
        #1 areset_n = 1'b0;
        #1 check_val("async_rst", 32'(dut_outs()), 32'(0));
        @(negedge clk);
        c = cyc;
        areset_n = 1'b1;
        expect_sequence(c + 2, NS, 8'd0);
        drain(200);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Global time limit so the bench always ends.
    initial begin
        #2000000;
        check_val("timeout", 32'(1), 32'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
